// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit branch predictor and its resolve queue.
package bp_pkg;

  localparam logic PRED_TAKEN     = 1'b1;
  localparam logic PRED_NOT_TAKEN = 1'b0;

  typedef enum logic [1:0] {
    ST_STRONG_NT = 2'b00,
    ST_WEAK_NT   = 2'b01,
    ST_WEAK_T    = 2'b10,
    ST_STRONG_T  = 2'b11
  } bp_state_e;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_CNT_W = 16;

endpackage

// File: rtl/brq_fifo.sv
// In-order 1-bit prediction storage with pointers, occupancy and a synchronous flush.
module brq_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     wr_data,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush discards every queued entry and any push arriving on the same edge.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH[PTR_W:0]);
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Checks in-flight branch predictions against resolved outcomes, flushes on mismatch and trains the predictor.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int CNT_W = BRQ_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   upd_valid,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   underflow,
  output logic [CNT_W-1:0]       mispred_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic head;
  logic full;
  logic do_push;
  logic do_pop;
  logic miss;

  assign pred_ready = !full;
  assign do_push    = pred_valid && pred_ready;
  assign do_pop     = res_valid && !empty;
  assign miss       = do_pop && (head != res_taken);

  brq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (do_push),
    .pop     (do_pop),
    .flush   (miss),
    .wr_data (pred_taken),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Registered pop results: training strobe and mispredict appear one cycle after the pop edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_valid   <= 1'b0;
      upd_taken   <= PRED_NOT_TAKEN;
      mispredict  <= 1'b0;
      underflow   <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      upd_valid  <= do_pop;
      upd_taken  <= do_pop && res_taken;
      mispredict <= miss;
      if (res_valid && empty) underflow <= 1'b1;
      if (miss) mispred_cnt <= sat_inc(mispred_cnt);
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed scoreboard bench for branch_resolve_queue; a second instance with a 2-bit counter covers saturation.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic pred_valid, pred_taken, res_valid, res_taken;

  logic        pred_ready, upd_valid, upd_taken, mispredict, empty, underflow;
  logic [2:0]  count;
  logic [15:0] mispred_cnt;

  logic        pred_ready2, upd_valid2, upd_taken2, mispredict2, empty2, underflow2;
  logic [2:0]  count2;
  logic [1:0]  mispred_cnt2;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .mispredict(mispredict),
    .count(count), .empty(empty), .underflow(underflow), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready2), .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid2), .upd_taken(upd_taken2), .mispredict(mispredict2),
    .count(count2), .empty(empty2), .underflow(underflow2), .mispred_cnt(mispred_cnt2)
  );

  typedef struct {
    bit uv, ut, mis, emp, rdy, und;
    int cnt, mcnt, mcnt2;
  } exp_t;

  exp_t sbq[$];
  bit   mq[$];
  bit   m_und;
  int   m_cnt, m_cnt2;
  int   passes = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.uv = 0; e.ut = 0; e.mis = 0;
    e.cnt = mq.size(); e.emp = (mq.size() == 0); e.rdy = (mq.size() != DEPTH);
    e.und = m_und; e.mcnt = m_cnt; e.mcnt2 = m_cnt2;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ":upd_valid"},   32'(upd_valid),    32'(e.uv));
    chk({tag, ":upd_taken"},   32'(upd_taken),    32'(e.ut));
    chk({tag, ":mispredict"},  32'(mispredict),   32'(e.mis));
    chk({tag, ":count"},       32'(count),        32'(e.cnt));
    chk({tag, ":empty"},       32'(empty),        32'(e.emp));
    chk({tag, ":pred_ready"},  32'(pred_ready),   32'(e.rdy));
    chk({tag, ":underflow"},   32'(underflow),    32'(e.und));
    chk({tag, ":mispred_cnt"}, 32'(mispred_cnt),  32'(e.mcnt));
    chk({tag, ":sat_cnt"},     32'(mispred_cnt2), 32'(e.mcnt2));
    chk({tag, ":upd_valid2"},  32'(upd_valid2),   32'(e.uv));
    chk({tag, ":count2"},      32'(count2),       32'(e.cnt));
  endtask

  task automatic step(input string tag, input bit pv, input bit pt, input bit rv, input bit rt);
    exp_t e;
    bit   rdy, pushok, h;
    pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
    rdy    = (mq.size() != DEPTH);
    pushok = pv && rdy;
    e.uv = 0; e.ut = 0; e.mis = 0;
    chk({tag, ":ready_pre"}, 32'(pred_ready), 32'(rdy));
    if (rv) begin
      if (mq.size() == 0) m_und = 1;
      else begin
        h = mq.pop_front();
        e.uv = 1; e.ut = rt;
        if (h != rt) begin
          e.mis = 1;
          mq.delete();
          pushok = 0;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
    if (pushok) mq.push_back(pt);
    begin
      exp_t s;
      s = model_state();
      e.cnt = s.cnt; e.emp = s.emp; e.rdy = s.rdy; e.und = s.und; e.mcnt = s.mcnt; e.mcnt2 = s.mcnt2;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    compare(tag, sbq.pop_front());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
    repeat (n) @(posedge clk);
    #1;
    mq.delete(); m_und = 0; m_cnt = 0; m_cnt2 = 0;
    compare("reset", model_state());
    reset = 1'b1;
  endtask

  initial begin
    m_und = 0; m_cnt = 0; m_cnt2 = 0;
    // 1: reset
    do_reset(3);

    // 2: fill, overflow, matching drain
    step("fill1", 1, 1, 0, 0);
    step("fill2", 1, 0, 0, 0);
    step("fill3", 1, 1, 0, 0);
    step("fill4", 1, 1, 0, 0);
    step("ovf",   1, 0, 0, 0);
    step("drain1", 0, 0, 1, 1);
    step("drain2", 0, 0, 1, 0);
    step("drain3", 0, 0, 1, 1);
    step("drain4", 0, 0, 1, 1);

    // 3: mispredict flush with a same-cycle push
    step("mp_push1", 1, 1, 0, 0);
    step("mp_push2", 1, 1, 0, 0);
    step("mp_push3", 1, 1, 0, 0);
    step("mp_flush", 1, 1, 1, 0);
    step("mp_after", 0, 0, 0, 0);

    // 4: simultaneous push/pop while full, then verify the tail via matching drain
    for (int i = 0; i < DEPTH; i++) step("full_fill", 1, 0, 0, 0);
    step("full_pp",  1, 1, 1, 0);
    step("pp3",      1, 1, 1, 0);
    step("tail_d1",  0, 0, 1, 0);
    step("tail_d2",  0, 0, 1, 0);
    step("tail_d3",  0, 0, 1, 1);

    // 5: underflow is sticky
    step("undf",      0, 0, 1, 1);
    step("undf_push", 1, 0, 0, 0);
    step("undf_pop",  0, 0, 1, 0);
    step("undf_idle", 0, 0, 0, 0);

    // 6: counter saturation, then mid-stream reset
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step("sat_push", 1, 1, 0, 0);
      step("sat_miss", 0, 0, 1, 0);
    end
    step("pre_rst1", 1, 1, 0, 0);
    step("pre_rst2", 1, 0, 0, 0);
    do_reset(1);
    step("post_rst1", 0, 0, 0, 0);
    step("post_rst2", 0, 0, 0, 0);
    step("post_push", 1, 0, 0, 0);
    step("post_pop",  0, 0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
